// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative radix-2 multiply/divide unit with HI/LO result registers.
//
// Executes MULT/MULTU/DIV/DIVU one bit per clock on operand magnitudes and applies the
// sign fix-up in a final cycle. It also owns the HI/LO registers, which MTHI/MTLO write
// directly while the unit is idle.
//
// Parameters:
//   WIDTH  operand width; hi and lo are WIDTH bits each (minimum 4)
//   CNT_W  iteration counter width (derived)
//
// Ports:
//   clock     in   system clock, rising edge
//   reset     in   asynchronous active-low reset
//   start     in   begin an operation (sampled only when idle)
//   op        in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled with start)
//   a, b      in   rs / rt operands (sampled with start)
//   abort     in   cancel the in-flight operation
//   hi_we     in   MTHI write strobe (idle only)
//   lo_we     in   MTLO write strobe (idle only)
//   wdata     in   MTHI/MTLO data
//   busy      out  operation in progress
//   done      out  one-cycle completion pulse
//   div_zero  out  divide-by-zero flag, only ever high together with done
//   hi, lo    out  HI (product high / remainder) and LO (product low / quotient)
//
// Build option:
//   MDU_EARLY_OUT_EN  when defined, multiplies leave RUN as soon as the remaining
//                     multiplier magnitude is zero (at least one step). Divides keep
//                     the fixed latency.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32,
    localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFinish
    } state_e;

    state_e               state_q, state_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_res_q, neg_res_d;   // product / quotient must be negated
    logic                 neg_rem_q, neg_rem_d;   // remainder takes the dividend's sign
    logic                 dz_q, dz_d;             // divide by zero detected at start
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;       // multiplicand, shifted left each step
    logic [WIDTH-1:0]     mplr_q, mplr_d;         // multiplier (shifts) or divisor (static)
    logic [2*WIDTH-1:0]   acc_q, acc_d;           // product, or {remainder, quotient}
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;
    logic                 div_zero_q, div_zero_d;

    // Operand magnitudes; unsigned ops pass the raw value through.
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    always_comb begin
        a_neg = ~op[0] & a[WIDTH-1];
        b_neg = ~op[0] & b[WIDTH-1];
        a_mag = a_neg ? ({WIDTH{1'b0}} - a) : a;
        b_mag = b_neg ? ({WIDTH{1'b0}} - b) : b;
    end

    // One radix-2 step of each algorithm.
    logic [2*WIDTH-1:0] mul_acc, div_acc;
    logic [WIDTH-1:0]   mplr_shift;
    logic [WIDTH:0]     rem_sh;
    logic               rem_ge;
    logic [WIDTH-1:0]   rem_diff;
    logic               last_step;

    always_comb begin
        mul_acc    = mplr_q[0] ? (acc_q + mcand_q) : acc_q;
        mplr_shift = mplr_q >> 1;

        // Partial remainder shifted left by one needs WIDTH+1 bits. When it is at least the
        // divisor the true difference is below the divisor, so WIDTH bits of it suffice.
        rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
        rem_ge   = (rem_sh >= {1'b0, mplr_q});
        rem_diff = rem_sh[WIDTH-1:0] - mplr_q;
        div_acc  = {(rem_ge ? rem_diff : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], rem_ge};

        last_step = (cnt_q == CNT_W'(WIDTH - 1));
`ifdef MDU_EARLY_OUT_EN
        if (!is_div_q && (mplr_shift == {WIDTH{1'b0}})) begin
            last_step = 1'b1;
        end
`endif
    end

    // Sign fix-up applied when results are written.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    always_comb begin
        prod_fix = neg_res_q ? ({(2*WIDTH){1'b0}} - acc_q) : acc_q;
        quot_fix = neg_res_q ? ({WIDTH{1'b0}} - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
        rem_fix  = neg_rem_q ? ({WIDTH{1'b0}} - acc_q[2*WIDTH-1:WIDTH])
                             : acc_q[2*WIDTH-1:WIDTH];
    end

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        dz_d       = dz_q;
        mcand_d    = mcand_q;
        mplr_d     = mplr_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        div_zero_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                // MTHI/MTLO land even if a start is accepted at the same edge; the
                // operation's own result overwrites them later.
                if (hi_we) begin
                    hi_d = wdata;
                end
                if (lo_we) begin
                    lo_d = wdata;
                end
                // abort wins over a coincident start.
                if (start && !abort) begin
                    is_div_d  = op[1];
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    dz_d      = op[1] && (b == {WIDTH{1'b0}});
                    cnt_d     = '0;
                    mplr_d    = b_mag;
                    if (op[1]) begin
                        mcand_d = '0;
                        acc_d   = {{WIDTH{1'b0}}, a_mag};
                    end else begin
                        mcand_d = {{WIDTH{1'b0}}, a_mag};
                        acc_d   = '0;
                    end
                    state_d = (op[1] && (b == {WIDTH{1'b0}})) ? StFinish : StRun;
                end
            end

            StRun: begin
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (is_div_q) begin
                        acc_d = div_acc;
                    end else begin
                        acc_d   = mul_acc;
                        mcand_d = mcand_q << 1;
                        mplr_d  = mplr_shift;
                    end
                    if (last_step) begin
                        state_d = StFinish;
                    end
                end
            end

            StFinish: begin
                state_d = StIdle;
                if (!abort) begin
                    done_d = 1'b1;
                    if (dz_q) begin
                        div_zero_d = 1'b1;
                    end else if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quot_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            dz_q       <= 1'b0;
            mcand_q    <= '0;
            mplr_q     <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            dz_q       <= dz_d;
            mcand_q    <= mcand_d;
            mplr_q     <= mplr_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy     = (state_q != StIdle);
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit (WIDTH=32).
// Expected results and latencies come from a behavioural model built on SystemVerilog
// arithmetic; they are queued at issue and compared when done is seen.
module tb_mult_div_unit;

    localparam int unsigned WIDTH = 32;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             abort;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;
    int          bc;
    int          dcnt;
    logic [31:0] hold_hi, hold_lo;
    logic [1:0]  ro;
    logic [31:0] rx, ry;

    mult_div_unit #(
        .WIDTH(WIDTH)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .abort    (abort),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [31:0] x,
                                   input logic [31:0] y);
        exp_t        e;
        longint      sx, sy, q, r;
        logic [63:0] p;
        logic [31:0] my;
        int          k;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        e.hi  = model_hi;
        e.lo  = model_lo;
        e.dz  = 1'b0;
        e.lat = WIDTH + 1;
        case (o)
            2'b00: begin
                p = sx * sy;
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            2'b01: begin
                p = {32'b0, x} * {32'b0, y};
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            2'b10: begin
                if (y == 32'd0) begin
                    e.dz  = 1'b1;
                    e.lat = 1;
                end else begin
                    q = sx / sy;
                    r = sx % sy;
                    e.lo = q[31:0];
                    e.hi = r[31:0];
                end
            end
            default: begin
                if (y == 32'd0) begin
                    e.dz  = 1'b1;
                    e.lat = 1;
                end else begin
                    e.lo = x / y;
                    e.hi = x % y;
                end
            end
        endcase
`ifdef MDU_EARLY_OUT_EN
        if (!o[1]) begin
            my = (!o[0] && y[31]) ? (32'd0 - y) : y;
            k  = 1;
            for (int i = 0; i < 32; i++) begin
                if (my[i]) k = i + 1;
            end
            e.lat = k + 1;
        end
`endif
        return e;
    endfunction

    // Called at a negedge; the start is sampled at the next posedge (edge N).
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        e = model(o, x, y);
        sb.push_back(e);
        model_hi = e.hi;
        model_lo = e.lo;
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
    endtask

    // n0 = number of edges already elapsed since edge N. Returns at the negedge where
    // done is high, so a following issue tests back-to-back acceptance.
    task automatic wait_done(input int n0, output int busy_cnt);
        int   n;
        exp_t e;
        n        = n0;
        busy_cnt = 0;
        while (!done && n < 100) begin
            if (busy) busy_cnt++;
            @(negedge clock);
            n++;
        end
        check("sb_size", 64'(sb.size()), 64'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check("done_seen", 64'(done), 64'd1);
        if (!done) return;
        check("latency", 64'(n), 64'(e.lat));
        check("hi", 64'(hi), 64'(e.hi));
        check("lo", 64'(lo), 64'(e.lo));
        check("div_zero", 64'(div_zero), 64'(e.dz));
    endtask

    task automatic write_hilo(input logic whi, input logic wlo, input logic [31:0] d);
        hi_we = whi;
        lo_we = wlo;
        wdata = d;
        @(negedge clock);
        hi_we = 1'b0;
        lo_we = 1'b0;
        if (whi) model_hi = d;
        if (wlo) model_lo = d;
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        abort = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = '0;
        repeat (2) @(negedge clock);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_div_zero", 64'(div_zero), 64'd0);
        reset = 1'b1;
        @(negedge clock);

        // Test plan vectors, checked against the model and the stated constants.
        issue(2'b00, 32'hFFFF_FFFD, 32'h0000_0007);
        wait_done(0, bc);
`ifdef MDU_EARLY_OUT_EN
        check("mult_busy_cycles", 64'(bc), 64'd4);
`else
        check("mult_busy_cycles", 64'(bc), 64'd33);
`endif
        check("mult_hi_const", 64'(hi), 64'hFFFF_FFFF);
        check("mult_lo_const", 64'(lo), 64'hFFFF_FFEB);

        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(0, bc);
        check("multu_hi_const", 64'(hi), 64'hFFFF_FFFE);
        check("multu_lo_const", 64'(lo), 64'h0000_0001);

        issue(2'b11, 32'd7, 32'd2);
        wait_done(0, bc);
        check("divu_lo_const", 64'(lo), 64'd3);
        check("divu_hi_const", 64'(hi), 64'd1);

        issue(2'b10, 32'hFFFF_FFF9, 32'd2);
        wait_done(0, bc);
        check("div_lo_const", 64'(lo), 64'hFFFF_FFFD);
        check("div_hi_const", 64'(hi), 64'hFFFF_FFFF);

        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(0, bc);
        check("divmin_lo_const", 64'(lo), 64'h8000_0000);
        check("divmin_hi_const", 64'(hi), 64'd0);

        @(negedge clock);
        write_hilo(1'b1, 1'b0, 32'h1234_5678);
        check("mthi", 64'(hi), 64'h1234_5678);
        write_hilo(1'b0, 1'b1, 32'h0BAD_F00D);
        check("mtlo", 64'(lo), 64'h0BAD_F00D);

        issue(2'b10, 32'd5, 32'd0);
        wait_done(0, bc);
        check("dz_hi_const", 64'(hi), 64'h1234_5678);
        check("dz_lo_const", 64'(lo), 64'h0BAD_F00D);
        @(negedge clock);
        check("dz_done_pulse", 64'(done), 64'd0);
        check("dz_flag_clear", 64'(div_zero), 64'd0);

        issue(2'b01, 32'h0000_0009, 32'h0000_0003);
        wait_done(0, bc);
        check("early_lo_const", 64'(lo), 64'h0000_001B);

        // MTHI together with an accepted start: the result overwrites it.
        hi_we = 1'b1;
        wdata = 32'hFFFF_0000;
        issue(2'b00, 32'd5, 32'd6);
        wait_done(0, bc);
        check("we_start_hi", 64'(hi), 64'd0);

        // A second start while busy must not disturb the operation in flight.
        issue(2'b01, 32'h0000_1234, 32'h0000_5678);
        repeat (4) @(negedge clock);
        op    = 2'b11;
        a     = 32'd100;
        b     = 32'd7;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done(5, bc);
        @(negedge clock);
        check("restart_ignored", 64'(busy), 64'd0);

        for (int i = 0; i < 16; i++) begin
            ro = 2'($urandom_range(0, 3));
            rx = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0:       ry = 32'd0;
                1:       ry = 32'h8000_0000;
                2:       ry = 32'hFFFF_FFFF;
                3:       ry = $urandom >> $urandom_range(0, 31);
                default: ry = $urandom;
            endcase
            issue(ro, rx, ry);
            wait_done(0, bc);
        end

        // Abort at the 10th RUN edge; an MTHI while busy is ignored.
        @(negedge clock);
        hold_hi = model_hi;
        hold_lo = model_lo;
        op    = 2'b00;
        a     = 32'h1111_1111;
        b     = 32'h7FFF_FFFF;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        hi_we = 1'b1;
        wdata = 32'hDEAD_BEEF;
        @(negedge clock);
        hi_we = 1'b0;
        repeat (5) @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        dcnt = 0;
        repeat (40) begin
            if (done) dcnt++;
            @(negedge clock);
        end
        check("abort_no_done", 64'(dcnt), 64'd0);
        check("abort_hi", 64'(hi), 64'(hold_hi));
        check("abort_lo", 64'(lo), 64'(hold_lo));

        // Reset in the middle of an operation.
        write_hilo(1'b1, 1'b1, 32'hA5A5_A5A5);
        op    = 2'b01;
        a     = 32'd3;
        b     = 32'hFFFF_FFFF;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(negedge clock);
        reset = 1'b0;
        #1;
        check("midrst_hi", 64'(hi), 64'd0);
        check("midrst_lo", 64'(lo), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_div_zero", 64'(div_zero), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        dcnt = 0;
        repeat (40) begin
            if (done) dcnt++;
            @(negedge clock);
        end
        check("midrst_no_done", 64'(dcnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
